// File: rtl/enigma_step_controller.sv
// enigma_step_controller
// Sequencer for the Enigma rotor/reflector datapath. It accepts one letter,
// steps the three rotors (odometer carry with notches), drives the letter into
// the combinational datapath, waits a settle time, captures the result and
// offers it on a valid/ready output. It owns all rotor position state.
//
// Optional feature: define ENIGMA_DOUBLE_STEP_EN to enable the historical
// middle-rotor double step.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1. in_ready is 1 only in IDLE and only when load is low. out_valid
// stays 1, with out_letter/out_err stable, until out_ready is seen.
module enigma_step_controller #(
    parameter logic [4:0] NOTCH0        = 5'd16,
    parameter logic [4:0] NOTCH1        = 5'd4,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       in_valid,
    input  logic [4:0] in_letter,
    output logic       in_ready,
    input  logic       load,
    input  logic [4:0] load_pos0,
    input  logic [4:0] load_pos1,
    input  logic [4:0] load_pos2,
    output logic [4:0] pos0,
    output logic [4:0] pos1,
    output logic [4:0] pos2,
    output logic [4:0] dp_letter,
    input  logic [4:0] dp_result,
    output logic       out_valid,
    output logic [4:0] out_letter,
    output logic       out_err,
    input  logic       out_ready,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic       accept;
    logic       letter_bad;
    logic       adv1;
    logic       adv2;
    logic [4:0] pos0_nx;
    logic [4:0] pos1_nx;
    logic [4:0] pos2_nx;

    // Increment with wrap 25 -> 0.
    function automatic logic [4:0] inc26(input logic [4:0] v);
        return (v == 5'd25) ? 5'd0 : v + 5'd1;
    endfunction

    // Reduce a 5-bit load value into 0..25.
    function automatic logic [4:0] mod26(input logic [4:0] v);
        return (v > 5'd25) ? v - 5'd26 : v;
    endfunction

    assign accept     = in_valid && in_ready;
    assign letter_bad = (in_letter > 5'd25);

    // Rotor stepping decision, evaluated on positions before the step.
    always_comb begin
`ifdef ENIGMA_DOUBLE_STEP_EN
        // Middle rotor sitting on its notch drags itself and the slow rotor along.
        adv1 = (pos0 == NOTCH0) || (pos1 == NOTCH1);
        adv2 = (pos1 == NOTCH1);
`else
        adv1 = (pos0 == NOTCH0);
        adv2 = adv1 && (pos1 == NOTCH1);
`endif
        pos0_nx = inc26(pos0);
        pos1_nx = adv1 ? inc26(pos1) : pos1;
        pos2_nx = adv2 ? inc26(pos2) : pos2;
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = letter_bad ? DONE : STEP;
            STEP:    state_nx = SETTLE;
            SETTLE:  if (cnt == 4'd0) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs; load in IDLE takes priority over a request.
    always_comb begin
        in_ready  = (state == IDLE) && !load;
        out_valid = (state == DONE);
        fsm_state = state;
    end

    // Rotor positions, datapath letter, settle counter and captured result.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pos0       <= 5'd0;
            pos1       <= 5'd0;
            pos2       <= 5'd0;
            dp_letter  <= 5'd0;
            out_letter <= 5'd0;
            out_err    <= 1'b0;
            cnt        <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load) begin
                        pos0 <= mod26(load_pos0);
                        pos1 <= mod26(load_pos1);
                        pos2 <= mod26(load_pos2);
                    end else if (accept) begin
                        dp_letter <= in_letter;
                        if (letter_bad) begin
                            out_err    <= 1'b1;
                            out_letter <= 5'd0;
                        end
                    end
                end
                STEP: begin
                    pos0 <= pos0_nx;
                    pos1 <= pos1_nx;
                    pos2 <= pos2_nx;
                    cnt  <= 4'(SETTLE_CYCLES - 1);
                end
                SETTLE: begin
                    if (cnt == 4'd0) begin
                        out_letter <= dp_result;
                        out_err    <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enigma_step_controller.sv
// tb_enigma_step_controller
// Directed bench for enigma_step_controller. Expected results are pushed into
// a queue at accept time and a monitor pops/compares on each output handshake.
// Define ENIGMA_DOUBLE_STEP_EN for both RTL and bench to exercise double step.
module tb_enigma_step_controller;

    localparam int SETTLE = 2;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic [4:0] in_letter = 5'd0;
    logic       in_ready;
    logic       load = 1'b0;
    logic [4:0] load_pos0 = 5'd0;
    logic [4:0] load_pos1 = 5'd0;
    logic [4:0] load_pos2 = 5'd0;
    logic [4:0] pos0;
    logic [4:0] pos1;
    logic [4:0] pos2;
    logic [4:0] dp_letter;
    logic [4:0] dp_result;
    logic       out_valid;
    logic [4:0] out_letter;
    logic       out_err;
    logic       out_ready = 1'b1;
    logic [1:0] fsm_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // {expected first-valid edge[15:0], err, letter}
    logic [21:0] exp_q[$];
    logic [21:0] e;
    int          first_edge = 0;
    bit          seen = 1'b0;

    enigma_step_controller #(
        .NOTCH0(5'd16),
        .NOTCH1(5'd4),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .in_valid(in_valid),
        .in_letter(in_letter),
        .in_ready(in_ready),
        .load(load),
        .load_pos0(load_pos0),
        .load_pos1(load_pos1),
        .load_pos2(load_pos2),
        .pos0(pos0),
        .pos1(pos1),
        .pos2(pos2),
        .dp_letter(dp_letter),
        .dp_result(dp_result),
        .out_valid(out_valid),
        .out_letter(out_letter),
        .out_err(out_err),
        .out_ready(out_ready),
        .fsm_state(fsm_state)
    );

    // Clock and edge counter.
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Stand-in datapath: result depends on the letter and the fast rotor.
    assign dp_result = 5'((int'(dp_letter) + 6 + int'(pos0)) % 26);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: record first valid edge, compare on handshake.
    always @(negedge clock) begin
        #1;
        if (!resetn) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                first_edge = cyc + 1;
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_letter", int'(out_letter), int'(e[4:0]));
                    chk("out_err", int'(out_err), int'(e[5]));
                    chk("latency_edge", first_edge, int'(e[21:6]));
                end
                seen = 1'b0;
            end
        end
    end

    task automatic do_load(input logic [4:0] p0, input logic [4:0] p1, input logic [4:0] p2);
        @(negedge clock);
        load = 1'b1;
        load_pos0 = p0;
        load_pos1 = p1;
        load_pos2 = p2;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic send(input logic [4:0] letter, input bit track,
                        input logic [4:0] exp_letter, input logic exp_err);
        int lat;
        int n;
        lat = exp_err ? 1 : 2 + SETTLE;
        @(negedge clock);
        in_valid = 1'b1;
        in_letter = letter;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk("accept_wait", int'(in_ready), 1);
        if (in_ready && track) exp_q.push_back({16'(cyc + 1 + lat), exp_err, exp_letter});
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clock);
            #2;
            n++;
        end
        chk("drain_queue", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic check_pos(input int p0, input int p1, input int p2);
        chk("pos0", int'(pos0), p0);
        chk("pos1", int'(pos1), p1);
        chk("pos2", int'(pos2), p2);
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // Directed stimulus.
    initial begin
        int n;
        repeat (3) @(negedge clock);
        #1;
        check_pos(0, 0, 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_letter", int'(out_letter), 0);
        chk("reset_out_err", int'(out_err), 0);
        chk("reset_dp_letter", int'(dp_letter), 0);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        chk("reset_in_ready", int'(in_ready), 1);

        // Basic: no carry, result 0+6+1 = 7.
        do_load(5'd0, 5'd0, 5'd0);
        send(5'd0, 1'b1, 5'd7, 1'b0);
        drain();
        check_pos(1, 0, 0);

        // Full carry with wrap on the slow rotor.
        do_load(5'd16, 5'd4, 5'd25);
        send(5'd3, 1'b1, 5'd0, 1'b0);
        drain();
        check_pos(17, 5, 0);

        // Fast rotor wrap without carry.
        do_load(5'd25, 5'd0, 5'd0);
        send(5'd10, 1'b1, 5'd16, 1'b0);
        drain();
        check_pos(0, 0, 0);

        // Double-step sequence.
        do_load(5'd16, 5'd3, 5'd0);
        send(5'd1, 1'b1, 5'd24, 1'b0);
        drain();
        check_pos(17, 4, 0);
        send(5'd2, 1'b1, 5'd0, 1'b0);
        drain();
`ifdef ENIGMA_DOUBLE_STEP_EN
        check_pos(18, 5, 1);
`else
        check_pos(18, 4, 0);
`endif

        // Load values above 25 are reduced.
        do_load(5'd30, 5'd26, 5'd31);
        #1;
        check_pos(4, 0, 5);

        // Back-pressure: result held, load ignored outside IDLE.
        out_ready = 1'b0;
        send(5'd5, 1'b1, 5'd16, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk("bp_valid_rise", int'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            load = (i == 3);
            load_pos0 = 5'd1;
            load_pos1 = 5'd1;
            load_pos2 = 5'd1;
            #1;
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_letter", int'(out_letter), 16);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        @(negedge clock);
        load = 1'b0;
        out_ready = 1'b1;
        drain();
        check_pos(5, 0, 5);

        // Load and request together: load wins, request refused.
        @(negedge clock);
        load = 1'b1;
        load_pos0 = 5'd2;
        load_pos1 = 5'd3;
        load_pos2 = 5'd4;
        in_valid = 1'b1;
        in_letter = 5'd9;
        #1;
        chk("prio_in_ready", int'(in_ready), 0);
        @(negedge clock);
        load = 1'b0;
        in_valid = 1'b0;
        #1;
        check_pos(2, 3, 4);
        chk("prio_idle_ready", int'(in_ready), 1);
        repeat (8) @(negedge clock);

        // Invalid letter: immediate error, no step.
        send(5'd27, 1'b1, 5'd0, 1'b1);
        drain();
        check_pos(2, 3, 4);

        // Reset during SETTLE discards the letter.
        do_load(5'd0, 5'd0, 5'd0);
        send(5'd4, 1'b0, 5'd0, 1'b0);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check_pos(0, 0, 0);
        chk("abort_out_valid", int'(out_valid), 0);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        chk("abort_in_ready", int'(in_ready), 1);
        repeat (12) @(negedge clock);
        #1;
        chk("abort_no_valid", int'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
